// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: bus-master sequencer that turns each TX stream word into one complete SPI core transfer
module spi_xfer_seq #(
    parameter logic [4:0]  ADDR_TX     = 5'h00,
    parameter logic [4:0]  ADDR_RX     = 5'h00,
    parameter logic [4:0]  ADDR_CTRL   = 5'h10,
    parameter logic [4:0]  ADDR_DIV    = 5'h14,
    parameter logic [31:0] DIV_VALUE   = 32'd4,
    parameter logic [31:0] CTRL_CFG    = 32'h0000_0008,
    parameter int          GO_BIT      = 8,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          POLL_MAX    = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    input  logic [31:0] i_tx_data,
    output logic        o_rx_valid,
    input  logic        i_rx_ready,
    output logic [31:0] o_rx_data,
    output logic [4:0]  o_addr,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic [3:0]  o_byte_sel,
    output logic        o_write_en,
    output logic        o_stb,
    output logic        o_cyc,
    input  logic        i_ack,
    input  logic        i_err,
    output logic        o_busy,
    output logic        o_err,
    input  logic        i_err_clr
);
    localparam int          WW      = $clog2(ACK_TIMEOUT + 1);
    localparam int          PW      = $clog2(POLL_MAX + 1);
    localparam logic [31:0] GO_WORD = CTRL_CFG | (32'd1 << GO_BIT);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_TX, S_WR_GO, S_POLL, S_RD_RX, S_OUT, S_GAP
    } state_t;

    state_t          r_state, r_ret, w_next, w_ret;
    logic            r_run;
    logic [31:0]     r_tx, r_rx;
    logic [WW-1:0]   r_wait;
    logic [PW-1:0]   r_poll;
    logic            r_err;
    logic            w_stb, w_we, w_ack, w_fault, w_go;
    logic [4:0]      w_addr;
    logic [31:0]     w_wdata;

    // Bus request for the current state, cycle outcome and next state; GAP returns to r_ret
    always_comb begin
        w_next  = r_state;
        w_ret   = r_ret;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            S_INIT: if (r_run) begin
                w_stb   = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_DIV;
                w_wdata = DIV_VALUE;
            end
            S_WR_TX: begin
                w_stb   = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_TX;
                w_wdata = r_tx;
            end
            S_WR_GO: begin
                w_stb   = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_CTRL;
                w_wdata = GO_WORD;
            end
            S_POLL: begin
                w_stb  = 1'b1;
                w_addr = ADDR_CTRL;
            end
            S_RD_RX: begin
                w_stb  = 1'b1;
                w_addr = ADDR_RX;
            end
            default: ;
        endcase
        w_go    = i_data[GO_BIT];
        w_ack   = w_stb && i_ack && !i_err;
        w_fault = w_stb && (i_err || (!i_ack && r_wait == WW'(ACK_TIMEOUT - 1)) ||
                  (r_state == S_POLL && i_ack && w_go && r_poll == PW'(POLL_MAX - 1)));
        if (w_fault)
            w_next = S_IDLE;
        else
            case (r_state)
                S_INIT:  if (w_ack) w_next = S_IDLE;
                S_IDLE:  if (i_tx_valid) w_next = S_WR_TX;
                S_WR_TX: if (w_ack) begin
                    w_next = S_GAP;
                    w_ret  = S_WR_GO;
                end
                S_WR_GO: if (w_ack) begin
                    w_next = S_GAP;
                    w_ret  = S_POLL;
                end
                S_POLL:  if (w_ack) begin
                    w_next = S_GAP;
                    w_ret  = w_go ? S_POLL : S_RD_RX;
                end
                S_RD_RX: if (w_ack) w_next = S_OUT;
                S_OUT:   if (i_rx_ready) w_next = S_IDLE;
                default: w_next = r_ret;
            endcase
    end

    // State register; reset parks the sequencer in INIT_DIV
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_INIT;
            r_ret   <= S_IDLE;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret;
        end
    end

    // Datapath: run flag delaying the first strobe, TX/RX words, wait and poll counters, sticky error
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run  <= 1'b0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_wait <= '0;
            r_poll <= '0;
            r_err  <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            if (r_state == S_IDLE && i_tx_valid)
                r_tx <= i_tx_data;
            if (r_state == S_RD_RX && w_ack)
                r_rx <= i_data;
            r_wait <= (w_stb && !i_ack && !i_err) ? r_wait + 1'b1 : '0;
            r_poll <= (r_state == S_WR_GO) ? '0 : (r_state == S_POLL && w_ack) ? r_poll + 1'b1 : r_poll;
            r_err  <= w_fault || (r_err && !i_err_clr);
        end
    end

    assign o_stb      = w_stb;
    assign o_cyc      = w_stb;
    assign o_addr     = w_addr;
    assign o_data     = w_wdata;
    assign o_write_en = w_we;
    assign o_byte_sel = {4{w_stb}};
    assign o_tx_ready = r_state == S_IDLE;
    assign o_rx_valid = r_state == S_OUT;
    assign o_rx_data  = r_rx;
    assign o_busy     = r_run && r_state != S_IDLE;
    assign o_err      = r_err;
endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Stream-to-bus transfer sequencer that sits directly upstream of the SPI master core and drives the core's register interface as a bus master. It programs the clock divider once after reset, then turns each accepted TX word into a complete SPI transfer: TX write, CTRL write with GO, CTRL polling until GO clears, and RX read. The received word is returned on a valid/ready output stream. Bus errors and timeouts set a sticky error flag.

## Interface
- ADDR_TX, 5'h00: core TX register address
- ADDR_RX, 5'h00: core RX register address
- ADDR_CTRL, 5'h10: core CTRL register address
- ADDR_DIV, 5'h14: core divider register address
- DIV_VALUE, 32'd4: divider value written during init
- CTRL_CFG, 32'h0000_0008: CTRL word for each transfer (char_len, lsb, tx/rx edge); GO must be 0 in this value
- GO_BIT, 8: bit index of GO in CTRL
- ACK_TIMEOUT, 255: maximum cycles a bus cycle may wait for ack/err
- POLL_MAX, 1023: maximum CTRL reads per transfer

Ports:
- i_clk, in, 1: sole clock, rising edge
- i_rst, in, 1: asynchronous, active-high reset
- i_tx_valid, in, 1: TX word offered
- o_tx_ready, out, 1: sequencer accepts TX word
- i_tx_data, in, 32: TX word
- o_rx_valid, out, 1: RX word available
- i_rx_ready, in, 1: consumer takes RX word
- o_rx_data, out, 32: RX word
- o_addr, out, 5: bus address
- o_data, out, 32: bus write data
- i_data, in, 32: bus read data
- o_byte_sel, out, 4: byte selects; 4'hF during every cycle, else 0
- o_write_en, out, 1: 1 = write, 0 = read
- o_stb, out, 1: strobe
- o_cyc, out, 1: bus cycle; always equal to o_stb
- i_ack, in, 1: cycle complete
- i_err, in, 1: cycle error
- o_busy, out, 1: any state other than IDLE
- o_err, out, 1: sticky error
- i_err_clr, in, 1: clears o_err

## Operation
- States: INIT_DIV, IDLE, WR_TX, WR_GO, POLL, RD_RX, OUT, plus a one-cycle GAP state after every bus cycle.
- INIT_DIV: write DIV_VALUE to ADDR_DIV, then go to IDLE. It is entered once after reset.
- IDLE: o_tx_ready=1. A handshake where i_tx_valid&&o_tx_ready are both high latches i_tx_data and moves to WR_TX.
- WR_TX: write the latched word to ADDR_TX.
- WR_GO: write CTRL_CFG | (1<<GO_BIT) to ADDR_CTRL.
- POLL: read ADDR_CTRL.
  - If i_data[GO_BIT]=1 on ack, repeat POLL after GAP.
  - If it is 0, go to RD_RX.
  - A poll counter counts reads; when POLL_MAX reads are reached, this is an error.
- RD_RX: read ADDR_RX and capture i_data into o_rx_data on ack. Then go to OUT.
- OUT: o_rx_valid=1 with o_rx_data stable until i_rx_ready=1, then go to IDLE. o_tx_ready stays 0 in OUT, so only one transfer is in flight.
- Bus cycle rules:
  - o_stb, o_cyc, o_addr, o_data and o_write_en are held constant from assertion until i_ack or i_err is sampled high.
  - o_stb drops the next cycle (GAP). There is never a back-to-back strobe.
- Error:
  - Sources are i_err on a cycle, a wait counter reaching ACK_TIMEOUT, or POLL_MAX exhausted.
  - Response: abort with strobe low next cycle, set o_err, go to IDLE. The TX word is dropped and no RX word is output.
  - An error in INIT_DIV still goes to IDLE.
  - If i_ack and i_err are high together, the error wins.
- i_err_clr clears o_err. If i_err_clr and a new error occur in the same cycle, the error wins.

## Timing
- Reset values:
  - All outputs 0, including o_tx_ready, o_rx_data and o_err.
  - State goes to INIT_DIV, and INIT_DIV's strobe asserts the first cycle after reset deasserts.
- Reset mid-transfer: all outputs clear immediately (asynchronously), and the in-flight word is lost.
- Latency with a slave that acks one cycle after strobe rises and a first poll that sees GO=0:
  - Accept at cycle 0.
  - WR_TX strobe in cycles 1–2; WR_GO in 4–5; POLL in 7–8; RD_RX in 10–11.
  - o_rx_valid=1 at cycle 12.
  - Each additional poll adds 3 cycles.
- Wait counter:
  - Counts cycles with o_stb=1 and no ack/err.
  - Error when it reaches ACK_TIMEOUT.
  - Cleared at every new strobe.
- o_tx_ready can rise at the earliest in the cycle after the OUT handshake.

## Test plan
- Reset release:
  - Required: one write at addr 5'h14, data 32'd4, byte_sel F.
  - Then o_tx_ready=1 and o_busy=0.
- Send 32'hA5 with the slave returning CTRL GO=1 twice and then 0, and RX=32'h3C:
  - Required: bus sequence is write 0x00=A5, write 0x10=0x108, three reads of 0x10, read 0x00.
  - o_rx_data=32'h3C.
  - Latency is 18 cycles.
- Hold i_rx_ready=0 for 10 cycles:
  - Required: o_rx_valid and o_rx_data stay stable.
  - o_tx_ready stays 0.
  - The word is accepted only after the OUT handshake.
- Assert i_err on WR_GO:
  - Required: o_err=1, return to IDLE, no o_rx_valid.
  - i_err_clr clears o_err.
  - The next transfer completes normally.
- Slave never acks:
  - Required: strobe drops after 255 wait cycles.
  - o_err=1 and state goes to IDLE.
- Assert i_rst during POLL:
  - Required: o_stb and all outputs are 0 immediately.
  - After release the divider write is repeated.
